// File: rtl/uart_rx_mp.sv
// 16x-oversampling 8N1 serial receiver for the Nios message-processor PIO pair.
// Holds one byte with a level valid flag until acknowledged; sticky overrun and framing errors.
module uart_rx_mp #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       rxd,
    input  logic       ack,
    input  logic       err_clr,
    output logic [7:0] mpdatain,
    output logic       chrec,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned DIV_RAW  = CLK_HZ / (BAUD * 16);
    localparam int unsigned DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state, state_n;
    logic          rxd_m, rxd_s;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    smp_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;

    logic smp_clr, bit_clr, shift_en, stop_ok, stop_bad;
    logic accept, ovr_set;

    // Two-flop synchroniser; resets to the idle-high line level.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n  = state;
        smp_clr  = 1'b0;
        bit_clr  = 1'b0;
        shift_en = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick && !rxd_s) begin
                    state_n = S_START;
                    smp_clr = 1'b1;
                end
            end
            S_START: begin
                // Mid start bit: a high line here means the low was only a glitch.
                if (tick && smp_cnt == 4'd7) begin
                    if (rxd_s) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_DATA;
                        smp_clr = 1'b1;
                        bit_clr = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick && smp_cnt == 4'd15) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick && smp_cnt == 4'd15) begin
                    if (rxd_s) begin
                        stop_ok = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_n  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (tick && rxd_s) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign accept  = stop_ok && (!chrec || ack);
    assign ovr_set = stop_ok && chrec && !ack;

    // The 4-bit sample counter wraps at 16, so DATA and STOP need no explicit clear.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            smp_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (smp_clr) begin
                smp_cnt <= '0;
            end else if (tick) begin
                smp_cnt <= smp_cnt + 1'b1;
            end
            if (bit_clr) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (shift_en) begin
                shift_reg <= {rxd_s, shift_reg[7:1]};
            end
        end
    end

    // An error event in the same clock as err_clr wins over the clear.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mpdatain  <= '0;
            chrec     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (accept) begin
                mpdatain <= shift_reg;
                chrec    <= 1'b1;
            end else if (ack) begin
                chrec    <= 1'b0;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
            if (stop_bad) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_mp.sv
// Directed and randomized frames for uart_rx_mp at 32 clocks per bit, checked against a
// frame-level model of the receive register, valid flag and sticky error flags.
module tb_uart_rx_mp;

    localparam int unsigned CLK_HZ   = 16_000_000;
    localparam int unsigned BAUD     = 500_000;
    localparam int          BIT_CLKS = 32;
    // Ticks from start detection to the stop sample: 8 + 8*16 + 16, two clocks per tick.
    localparam int          DET_TO_STOP = 304;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic       rxd = 1'b1;
    logic       ack = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] mpdatain;
    logic       chrec, overrun, frame_err, busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_data = 8'h00;
    logic       m_chrec = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;

    uart_rx_mp #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .rxd          (rxd),
        .ack          (ack),
        .err_clr      (err_clr),
        .mpdatain     (mpdatain),
        .chrec        (chrec),
        .overrun      (overrun),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk_clk = ~clk_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
        $fatal(1, "watchdog expired");
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check8({tag, "_data"}, mpdatain, m_data);
        check1({tag, "_chrec"}, chrec, m_chrec);
        check1({tag, "_overrun"}, overrun, m_ovr);
        check1({tag, "_frame_err"}, frame_err, m_ferr);
    endtask

    // Drives one 8N1 frame starting at the current negedge; a bad stop bit holds the line
    // low for hold_low clocks. The model is updated once the frame is complete.
    task automatic send_frame(input logic [7:0] b, input logic stop_good, input int hold_low);
        rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk_clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT_CLKS) @(negedge clk_clk);
        end
        rxd = stop_good;
        repeat (stop_good ? BIT_CLKS : hold_low) @(negedge clk_clk);
        rxd = 1'b1;
        if (!stop_good) begin
            m_ferr = 1'b1;
        end else if (!m_chrec) begin
            m_data  = b;
            m_chrec = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk_clk);
        ack = 1'b0;
        m_chrec = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk_clk);
        err_clr = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    initial begin
        logic       found;
        logic       seen;
        logic [7:0] rb;
        logic       rgood;

        // Reset state
        repeat (3) @(negedge clk_clk);
        check_model("rst");
        check1("rst_busy", busy, 1'b0);
        reset_reset_n = 1'b1;
        idle(40);

        // 1: frame 0xA5 with latency bound, then ack
        found = 1'b0;
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                for (int i = 0; i < 310; i++) begin
                    @(posedge clk_clk);
                    #1;
                    if (chrec === 1'b1) begin
                        found = 1'b1;
                        break;
                    end
                end
            end
        join
        check1("t1_latency", found, 1'b1);
        check_model("t1_frame");
        check8("t1_a5", mpdatain, 8'hA5);
        idle(10);
        pulse_ack();
        check1("t1_ack_chrec", chrec, 1'b0);
        check8("t1_ack_data", mpdatain, 8'hA5);
        idle(40);

        // 2: 8-clock low glitch is rejected
        seen = 1'b0;
        rxd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_clk);
            if (busy === 1'b1) seen = 1'b1;
        end
        rxd = 1'b1;
        check1("t2_busy_seen", seen, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_clk);
            if (busy === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check1("t2_busy_drop", found, 1'b1);
        idle(80);
        check_model("t2_idle");
        check1("t2_chrec", chrec, 1'b0);

        // 3: bad stop bit with long break, then a good frame
        send_frame(8'h3C, 1'b0, 200);
        idle(40);
        check_model("t3_break");
        check1("t3_ferr", frame_err, 1'b1);
        send_frame(8'h11, 1'b1, 0);
        idle(20);
        check_model("t3_next");
        check8("t3_11", mpdatain, 8'h11);
        check1("t3_ferr_sticky", frame_err, 1'b1);
        pulse_ack();
        pulse_err_clr();
        check_model("t3_clr");
        idle(40);

        // 4: back-to-back frames without ack
        send_frame(8'h01, 1'b1, 0);
        send_frame(8'h02, 1'b1, 0);
        idle(20);
        check_model("t4_b2b");
        check1("t4_overrun", overrun, 1'b1);
        check8("t4_keep01", mpdatain, 8'h01);
        pulse_err_clr();
        check_model("t4_clr");
        idle(40);

        // 5: ack lands exactly on the stop-sample clock of 0x7E
        found = 1'b0;
        fork
            send_frame(8'h7E, 1'b1, 0);
            begin
                for (int i = 0; i < 50 && busy !== 1'b1; i++) @(negedge clk_clk);
                if (busy === 1'b1) begin
                    found = 1'b1;
                    repeat (DET_TO_STOP - 1) @(posedge clk_clk);
                    @(negedge clk_clk);
                    ack = 1'b1;
                    m_chrec = 1'b0;
                    @(negedge clk_clk);
                    ack = 1'b0;
                end
            end
        join
        check1("t5_start_seen", found, 1'b1);
        idle(10);
        check_model("t5_ack_at_stop");
        check8("t5_7e", mpdatain, 8'h7E);
        check1("t5_no_ovr", overrun, 1'b0);
        idle(40);

        // Random frames, acks and error clears against the model
        for (int n = 0; n < 10; n++) begin
            rb    = 8'($urandom);
            rgood = ($urandom_range(3) != 0);
            send_frame(rb, rgood, 40);
            idle(40);
            check_model($sformatf("rnd%0d_frame", n));
            if ($urandom_range(1) == 1) pulse_ack();
            if ($urandom_range(3) == 0) pulse_err_clr();
            check_model($sformatf("rnd%0d_post", n));
            idle(30);
        end

        // 6: reset mid-data of 0xFF, then 0x5A
        if (!m_chrec) begin
            send_frame(8'hC3, 1'b1, 0);
            idle(40);
        end
        rxd = 1'b0;
        idle(BIT_CLKS);
        rxd = 1'b1;
        idle(3 * BIT_CLKS);
        check1("t6_busy_mid", busy, 1'b1);
        reset_reset_n = 1'b0;
        #1;
        m_data = 8'h00; m_chrec = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
        check_model("t6_reset");
        check1("t6_reset_busy", busy, 1'b0);
        idle(5);
        reset_reset_n = 1'b1;
        idle(40);
        send_frame(8'h5A, 1'b1, 0);
        idle(20);
        check_model("t6_after");
        check8("t6_5a", mpdatain, 8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
